// File: rtl/traffic_pkg.sv
// Shared types for the N-way traffic controller: lamp encodings, FSM states,
// and a small constant helper used to size the phase timer.
package traffic_pkg;

  typedef enum logic [1:0] {
    LT_GREEN  = 2'b00,
    LT_YELLOW = 2'b01,
    LT_RED    = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10,
    ST_WALK   = 2'b11
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin successor search: first waiting direction after cur_dir (wrapping,
// ending on cur_dir itself); with no demand anywhere it simply steps to cur_dir+1.
module rr_next_dir #(
  parameter int NUM_DIR = 4,
  parameter int DW      = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] sensor,
  input  logic [DW-1:0]      cur_dir,
  output logic [DW-1:0]      next_dir
);

  always_comb begin
    logic          found;
    logic [DW-1:0] idx;
    found    = 1'b0;
    idx      = '0;
    next_dir = DW'((int'(cur_dir) + 1) % NUM_DIR);
    for (int k = 1; k <= NUM_DIR; k++) begin
      idx = DW'((int'(cur_dir) + k) % NUM_DIR);
      if (!found && sensor[idx]) begin
        next_dir = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-way intersection controller: GREEN -> YELLOW -> ALLRED -> (WALK) -> GREEN,
// Moore lamp outputs, latched pedestrian request, round-robin direction handoff.
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int NUM_DIR    = 4,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 5,
  localparam int DW        = $clog2(NUM_DIR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DIR-1:0]   sensor,
  input  logic                 ped_req,
  output logic [2*NUM_DIR-1:0] light,
  output logic [DW-1:0]        cur_dir,
  output logic                 ped_walk
);

  localparam int MAXP = max_int(max_int(GREEN_MIN, GREEN_MAX),
                                max_int(max_int(YELLOW_CYC, ALLRED_CYC), WALK_CYC));
  localparam int TW   = $clog2(MAXP) + 1;

  if (NUM_DIR < 2 || NUM_DIR > 8 || GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN ||
      YELLOW_CYC < 1 || ALLRED_CYC < 1 || WALK_CYC < 1) begin : g_param_err
    $error("traffic_ctrl_n: illegal parameter set");
  end

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] cur_dir_q, cur_dir_d;
  logic          ped_pend_q, ped_pend_d;
  logic [DW-1:0] next_dir;

  logic [NUM_DIR-1:0] other_sensor;
  logic               own_sensor;
  logic               other_demand;
  logic               walk_entry;

  rr_next_dir #(
    .NUM_DIR (NUM_DIR),
    .DW      (DW)
  ) u_rr_next_dir (
    .sensor   (sensor),
    .cur_dir  (cur_dir_q),
    .next_dir (next_dir)
  );

  always_comb begin
    other_sensor            = sensor;
    other_sensor[cur_dir_q] = 1'b0;
    own_sensor              = sensor[cur_dir_q];
    other_demand            = (|other_sensor) | ped_pend_q;
  end

  // Only GREEN looks at sensors; the clearance states run purely on the timer.
  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir_q;
    case (state_q)
      ST_GREEN: begin
        if (timer_q >= TW'(GREEN_MIN - 1) && other_demand &&
            (!own_sensor || timer_q >= TW'(GREEN_MAX - 1)))
          state_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (timer_q == TW'(YELLOW_CYC - 1))
          state_d = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (timer_q == TW'(ALLRED_CYC - 1)) begin
          if (ped_pend_q) begin
            state_d = ST_WALK;
          end else begin
            state_d   = ST_GREEN;
            cur_dir_d = next_dir;
          end
        end
      end
      ST_WALK: begin
        if (timer_q == TW'(WALK_CYC - 1)) begin
          state_d   = ST_GREEN;
          cur_dir_d = next_dir;
        end
      end
      default: state_d = ST_GREEN;
    endcase
  end

  always_comb begin
    walk_entry = (state_q != ST_WALK) && (state_d == ST_WALK);
    ped_pend_d = ped_req | (ped_pend_q & ~walk_entry);
    if (state_d != state_q)
      timer_d = '0;
    else if (timer_q == {TW{1'b1}})
      timer_d = timer_q;
    else
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_GREEN;
      timer_q    <= '0;
      cur_dir_q  <= '0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cur_dir_q  <= cur_dir_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  always_comb begin
    light_t lamp;
    light = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      lamp = LT_RED;
      if (DW'(i) == cur_dir_q) begin
        if (state_q == ST_GREEN)
          lamp = LT_GREEN;
        else if (state_q == ST_YELLOW)
          lamp = LT_YELLOW;
      end
      light[2*i +: 2] = lamp;
    end
  end

  assign cur_dir  = cur_dir_q;
  assign ped_walk = (state_q == ST_WALK);

`ifndef SYNTHESIS
  // ASCII state name for waveform viewing only.
  logic [47:0] dbg_state_unused;
  always_comb begin
    dbg_state_unused = "GREEN ";
    case (state_q)
      ST_YELLOW: dbg_state_unused = "YELLOW";
      ST_ALLRED: dbg_state_unused = "ALLRED";
      ST_WALK:   dbg_state_unused = "WALK  ";
      default:   dbg_state_unused = "GREEN ";
    endcase
  end
`endif

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Scoreboard bench: stimulus queues the expected phase changes, the monitor
// pops one per observed output change and checks outputs plus previous-phase length.
module tb_traffic_ctrl_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sensor;
  logic       ped_req;
  logic [7:0] light;
  logic [1:0] cur_dir;
  logic       ped_walk;

  typedef struct {
    logic [7:0] light;
    logic [1:0] dir;
    logic       walk;
    int         dur;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  traffic_ctrl_n #(
    .NUM_DIR    (4),
    .GREEN_MIN  (4),
    .GREEN_MAX  (16),
    .YELLOW_CYC (3),
    .ALLRED_CYC (2),
    .WALK_CYC   (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sensor   (sensor),
    .ped_req  (ped_req),
    .light    (light),
    .cur_dir  (cur_dir),
    .ped_walk (ped_walk)
  );

  // dur = length in cycles of the phase that just ended; -1 = don't care
  task automatic expect_ev(input logic [7:0] l, input logic [1:0] d, input logic w, input int dur);
    exp_t e;
    e.light = l;
    e.dir   = d;
    e.walk  = w;
    e.dur   = dur;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [3:0] s);
    @(posedge clk);
    #2 reset = 1'b1;
    sensor  = s;
    ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1 n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d expected phase changes never seen, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : monitor
    logic [10:0] prev;
    logic [10:0] cur;
    int          cnt;
    exp_t        e;
    prev = '0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      cur = {light, cur_dir, ped_walk};
      if (reset) begin
        tests++;
        if (cur !== {8'hA8, 2'd0, 1'b0}) begin
          fails++;
          $display("FAIL reset_out: light=%h dir=%0d walk=%b, want light=a8 dir=0 walk=0",
                   light, cur_dir, ped_walk);
        end
        prev = cur;
        cnt  = 0;
      end else if (cur !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: light=%h dir=%0d walk=%b after %0d cycles, want no change",
                   light, cur_dir, ped_walk, cnt);
        end else begin
          e = exp_q.pop_front();
          if (light !== e.light || cur_dir !== e.dir || ped_walk !== e.walk ||
              (e.dur >= 0 && cnt != e.dur)) begin
            fails++;
            $display("FAIL phase_change: got light=%h dir=%0d walk=%b prev_len=%0d, want light=%h dir=%0d walk=%b prev_len=%0d",
                     light, cur_dir, ped_walk, cnt, e.light, e.dir, e.walk, e.dur);
          end
        end
        prev = cur;
        cnt  = 1;
      end else begin
        cnt++;
      end
    end
  end

  initial begin : stimulus
    reset   = 1'b1;
    sensor  = 4'b0000;
    ped_req = 1'b0;

    // No demand: dir0 must hold GREEN with no phase change for 50 cycles.
    do_reset(4'b0000);
    repeat (50) @(posedge clk);

    // Demand only on dir2: minimum green, then handoff skipping dir1.
    expect_ev(8'hA9, 2'd0, 1'b0, 4);
    expect_ev(8'hAA, 2'd0, 1'b0, 3);
    expect_ev(8'h8A, 2'd2, 1'b0, 2);
    do_reset(4'b0100);
    wait_drain(40, "min_green");
    repeat (10) @(posedge clk);

    // Contested demand on 0,1,3: max-green cap, dir2 skipped, wrap to dir0.
    expect_ev(8'hA9, 2'd0, 1'b0, 16);
    expect_ev(8'hAA, 2'd0, 1'b0, 3);
    expect_ev(8'hA2, 2'd1, 1'b0, 2);
    expect_ev(8'hA6, 2'd1, 1'b0, 16);
    expect_ev(8'hAA, 2'd1, 1'b0, 3);
    expect_ev(8'h2A, 2'd3, 1'b0, 2);
    expect_ev(8'h6A, 2'd3, 1'b0, 16);
    expect_ev(8'hAA, 2'd3, 1'b0, 3);
    expect_ev(8'hA8, 2'd0, 1'b0, 2);
    expect_ev(8'hA9, 2'd0, 1'b0, 16);
    do_reset(4'b1011);
    wait_drain(200, "max_green_rr");

    // Single pedestrian pulse: one WALK, then dir1 GREEN holds.
    expect_ev(8'hA9, 2'd0, 1'b0, 8);
    expect_ev(8'hAA, 2'd0, 1'b0, 3);
    expect_ev(8'hAA, 2'd0, 1'b1, 2);
    expect_ev(8'hA2, 2'd1, 1'b0, 5);
    do_reset(4'b0000);
    repeat (6) @(posedge clk);
    #2 ped_req = 1'b1;
    @(posedge clk);
    #2 ped_req = 1'b0;
    wait_drain(60, "ped_walk");
    repeat (20) @(posedge clk);

    // Pedestrian pulse on the WALK-entry edge re-arms a second WALK.
    expect_ev(8'hA9, 2'd0, 1'b0, 8);
    expect_ev(8'hAA, 2'd0, 1'b0, 3);
    expect_ev(8'hAA, 2'd0, 1'b1, 2);
    expect_ev(8'hA2, 2'd1, 1'b0, 5);
    expect_ev(8'hA6, 2'd1, 1'b0, 4);
    expect_ev(8'hAA, 2'd1, 1'b0, 3);
    expect_ev(8'hAA, 2'd1, 1'b1, 2);
    expect_ev(8'h8A, 2'd2, 1'b0, 5);
    do_reset(4'b0000);
    repeat (6) @(posedge clk);
    #2 ped_req = 1'b1;
    @(posedge clk);
    #2 ped_req = 1'b0;
    repeat (5) @(posedge clk);
    #2 ped_req = 1'b1;
    @(posedge clk);
    #2 ped_req = 1'b0;
    wait_drain(80, "ped_rearm");
    repeat (30) @(posedge clk);

    // Reset mid-YELLOW of dir2 with a pending pedestrian: back to dir0, no WALK afterwards.
    expect_ev(8'hA9, 2'd0, 1'b0, 4);
    expect_ev(8'hAA, 2'd0, 1'b0, 3);
    expect_ev(8'h8A, 2'd2, 1'b0, 2);
    do_reset(4'b0100);
    wait_drain(40, "reach_dir2");
    expect_ev(8'h9A, 2'd2, 1'b0, -1);
    @(posedge clk);
    #2 sensor = 4'b0001;
    wait_drain(20, "dir2_yellow");
    @(posedge clk);
    #2 ped_req = 1'b1;
    @(posedge clk);
    #2 ped_req = 1'b0;
    reset  = 1'b1;
    sensor = 4'b0000;
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (40) @(posedge clk);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover: %0d expected phase changes unseen, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_n.md
TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

Interface
REQ-001 Parameter NUM_DIR, default 4: number of approach directions, legal range 2..8.
REQ-002 Parameter GREEN_MIN, default 4: minimum green cycles, at least 1.
REQ-003 Parameter GREEN_MAX, default 16: maximum green cycles while other demand exists, at least GREEN_MIN.
REQ-004 Parameter YELLOW_CYC, default 3: yellow duration in cycles, at least 1.
REQ-005 Parameter ALLRED_CYC, default 2: all-red clearance in cycles, at least 1.
REQ-006 Parameter WALK_CYC, default 5: pedestrian walk duration in cycles, at least 1.
REQ-007 clk  in  1  single system clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 sensor  in  NUM_DIR  bit i = vehicle waiting on direction i; level-sensitive.
REQ-010 ped_req  in  1  pedestrian button; a one-cycle pulse shall suffice.
REQ-011 light  out  2*NUM_DIR  bits [2i+1:2i] = lamp of direction i; GREEN=00, YELLOW=01, RED=10; 11 never driven.
REQ-012 cur_dir  out  $clog2(NUM_DIR)  index of the direction owning the current phase.
REQ-013 ped_walk  out  1  high only in WALK state.

Function
REQ-014 FSM states: GREEN, YELLOW, ALLRED, WALK; outputs shall be Moore, decoded from state and cur_dir only.
REQ-015 Timer (width $clog2(max parameter)+1) shall clear to 0 on every state entry and increment each cycle in state, saturating.
REQ-016 GREEN: light[cur_dir]=GREEN, all others RED.
REQ-017 "Other demand" = any sensor bit j≠cur_dir set, or ped_pend set.
REQ-018 GREEN -> YELLOW when timer ≥ GREEN_MIN-1 and other demand and (sensor[cur_dir]=0 or timer ≥ GREEN_MAX-1); otherwise hold GREEN indefinitely.
REQ-019 YELLOW: light[cur_dir]=YELLOW, others RED; -> ALLRED when timer = YELLOW_CYC-1 (exactly YELLOW_CYC cycles).
REQ-020 ALLRED: all RED; lasts exactly ALLRED_CYC cycles, then -> WALK if ped_pend, else -> GREEN on next direction.
REQ-021 Next direction: first j with sensor[j]=1 searching cur_dir+1, cur_dir+2, ... modulo NUM_DIR (round-robin, wrap-around); if none, cur_dir+1 mod NUM_DIR; cur_dir updates on ALLRED/WALK -> GREEN.
REQ-022 WALK: all RED, ped_walk=1, exactly WALK_CYC cycles, then -> GREEN on next direction per REQ-021 evaluated at exit.
REQ-023 ped_pend shall set on ped_req=1 in any state and clear on the WALK-entry edge; ped_req coincident with WALK entry shall leave ped_pend set (set wins).
REQ-024 Sensor changes during YELLOW, ALLRED or WALK shall not shorten or extend those states.
REQ-025 Only one direction shall ever be non-RED; no GREEN->GREEN handoff without YELLOW and ALLRED in between.

Reset
REQ-026 While reset=1: state=GREEN, cur_dir=0, timer=0, ped_pend=0, independent of clk.
REQ-027 Reset outputs: light = direction 0 GREEN, all others RED; ped_walk=0; cur_dir=0.
REQ-028 Reset asserted mid-phase (any state) shall force REQ-026 values immediately; first transition after release follows REQ-018 with timer from 0.

Structure
REQ-029 Package traffic_pkg shall hold light_t (GREEN/YELLOW/RED encodings) and state_t enum.
REQ-030 Round-robin next-direction search shall be a sub-module rr_next_dir (inputs sensor, cur_dir; output next index), purely combinational.
REQ-031 Simulation-only state-name debug signal shall be excluded from synthesis.

Verification (NUM_DIR=4, GREEN_MIN=4, GREEN_MAX=16, YELLOW_CYC=3, ALLRED_CYC=2, WALK_CYC=5)
REQ-032 Reset, sensor=0000 for 50 cycles -> dir0 GREEN throughout, light=8'b10_10_10_00, ped_walk=0.
REQ-033 sensor=0100 from cycle 0 after reset -> GREEN 4 cycles, YELLOW 3, ALLRED 2, then cur_dir=2 GREEN.
REQ-034 sensor=1011 held, cur_dir=0 -> dir0 GREEN exactly 16 cycles, then dir1, then dir3 (dir2 skipped), then dir0 (wrap).
REQ-035 One-cycle ped_req during dir0 GREEN, sensor=0000 -> YELLOW, ALLRED, WALK 5 cycles with ped_walk=1 and all RED, then dir1 GREEN.
REQ-036 ped_req pulse on WALK-entry edge -> second WALK follows the next green phase.
REQ-037 Reset pulse during YELLOW of dir2 -> outputs return to dir0 GREEN within the reset cycle, ped_pend=0.
